// File: rtl/ob_port_arb.sv
// ob_port_arb: round-robin command ingress arbiter with uid stamping and unicast/broadcast response routing
package ob_pkg;
  localparam int UID_W = 12;
  typedef struct packed {
    logic [1:0]       op;
    logic [UID_W-1:0] uid;
    logic [15:0]      data;
  } cmd_t;
  typedef struct packed {
    logic [UID_W-1:0] uid;
    logic [15:0]      data;
  } rsp_t;
endpackage

module ob_port_arb
  import ob_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS),
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   cmd_in_vld,
  input  cmd_t [N_PORTS-1:0]   cmd_in,
  output logic [N_PORTS-1:0]   cmd_in_accept,
  input  logic                 cmd_out_full_r,
  output logic                 cmd_out_vld,
  output cmd_t                 cmd_out,
  input  logic                 rsp_in_vld,
  input  rsp_t                 rsp_in,
  output logic                 rsp_in_pop,
  input  logic [N_PORTS-1:0]   rsp_out_full_r,
  output logic [N_PORTS-1:0]   rsp_out_vld,
  output rsp_t                 rsp_out,
  output logic [CNT_W-1:0]     bad_uid_cnt_r,
  output logic [CNT_W-1:0]     drop_cnt_r
);
  localparam logic [N_PORTS-1:0] ONE = N_PORTS'(1);
  typedef enum logic [1:0] {R_IDLE, R_UNI, R_BCAST} r_state_t;
  logic [PORT_W-1:0]  rr_ptr, gnt, dst;
  logic               gnt_found, free, take, bad;
  cmd_t               stamped;
  r_state_t           r_state;
  logic [N_PORTS-1:0] mask, dlv;
  // Descending scan so the last hit is the port closest to rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt = rr_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--)
      if (cmd_in_vld[rr_ptr + PORT_W'(k)]) begin
        gnt_found = 1'b1;
        gnt = rr_ptr + PORT_W'(k);
      end
  end
  always_comb begin
    stamped = cmd_in[gnt];
    stamped.uid[UID_W-1 -: PORT_W] = gnt;
  end
  assign free = ~cmd_out_vld | ~cmd_out_full_r;
  assign take = rst & free & gnt_found;
  assign bad = &stamped.uid;
  assign cmd_in_accept = take ? ONE << gnt : '0;
  assign drop_cnt_r = '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_out_vld <= 1'b0;
      cmd_out <= '0;
      rr_ptr <= '0;
      bad_uid_cnt_r <= '0;
    end else begin
      if (free) cmd_out_vld <= take & ~bad;
      if (take & ~bad) cmd_out <= stamped;
      if (take) rr_ptr <= gnt + 1'b1;
      if (take & bad & ~&bad_uid_cnt_r) bad_uid_cnt_r <= bad_uid_cnt_r + 1'b1;
    end
  end
  assign rsp_in_pop = rst & (r_state == R_IDLE) & rsp_in_vld;
  always_comb
    dlv = ~rst ? '0 :
          r_state == R_UNI   ? (ONE << dst) & ~rsp_out_full_r :
          r_state == R_BCAST ? ~mask & ~rsp_out_full_r : '0;
  assign rsp_out_vld = dlv;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      rsp_out <= '0;
      dst <= '0;
      mask <= '0;
    end else if (rsp_in_pop) begin
      rsp_out <= rsp_in;
      dst <= rsp_in.uid[UID_W-1 -: PORT_W];
      mask <= '0;
      r_state <= &rsp_in.uid ? R_BCAST : R_UNI;
    end else if (r_state == R_UNI && |dlv) begin
      r_state <= R_IDLE;
    end else if (r_state == R_BCAST) begin
      mask <= mask | dlv;
      if (&(mask | dlv)) r_state <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_ob_port_arb.sv
// tb_ob_port_arb: randomized bench against a set-of-owed-ports / round-robin reference model
module tb_ob_port_arb;
  import ob_pkg::*;
  localparam int N = 4;
  localparam int PW = 2;
  localparam int CW = 8;
  localparam int LOW_W = UID_W - PW;
  localparam int UID_ONES = (1 << UID_W) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] cmd_in_vld, cmd_in_accept, rsp_out_full_r, rsp_out_vld;
  cmd_t [N-1:0] cmd_in;
  logic cmd_out_full_r, cmd_out_vld, rsp_in_vld, rsp_in_pop;
  cmd_t cmd_out;
  rsp_t rsp_in, rsp_out;
  logic [CW-1:0] bad_uid_cnt_r, drop_cnt_r;
  int n_cmp = 0, n_bad = 0;
  bit m_vld, m_busy;
  cmd_t m_cmd;
  rsp_t m_rsp;
  int m_rr, m_bc;
  logic [N-1:0] m_owed;

  ob_port_arb #(.N_PORTS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_in_vld(cmd_in_vld), .cmd_in(cmd_in),
    .cmd_in_accept(cmd_in_accept), .cmd_out_full_r(cmd_out_full_r),
    .cmd_out_vld(cmd_out_vld), .cmd_out(cmd_out), .rsp_in_vld(rsp_in_vld),
    .rsp_in(rsp_in), .rsp_in_pop(rsp_in_pop), .rsp_out_full_r(rsp_out_full_r),
    .rsp_out_vld(rsp_out_vld), .rsp_out(rsp_out), .bad_uid_cnt_r(bad_uid_cnt_r),
    .drop_cnt_r(drop_cnt_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_busy = 0; m_rr = 0; m_bc = 0; m_owed = '0;
    m_cmd = '0; m_rsp = '0;
  endtask

  // mode 0: random, 1: port 3 floods reserved uids, 2: random with resets, 3: all ports stream
  task automatic drive(input int mode);
    for (int p = 0; p < N; p++) begin
      cmd_in[p].op = 2'($urandom);
      cmd_in[p].data = 16'($urandom);
      cmd_in[p].uid = UID_W'($urandom);
      if ($urandom_range(0, 3) == 0 || mode == 1) cmd_in[p].uid[LOW_W-1:0] = '1;
    end
    cmd_in_vld = mode == 1 ? 4'b1000 : mode == 3 ? 4'b1111 : N'($urandom);
    cmd_out_full_r = (mode == 1 || mode == 3) ? 1'b0 : $urandom_range(0, 2) == 0;
    rsp_in_vld = $urandom_range(0, 1) == 1;
    rsp_in.data = 16'($urandom);
    rsp_in.uid = $urandom_range(0, 2) == 0 ? UID_W'(UID_ONES) : UID_W'($urandom);
    rsp_out_full_r = mode == 2 ? N'($urandom | $urandom) : N'($urandom & $urandom);
    rst = !(mode == 2 && $urandom_range(0, 19) == 0);
  endtask

  task automatic step(input int mode);
    int g, stamp;
    bit found, free, bad;
    logic [N-1:0] exp_acc, exp_dlv;
    @(negedge clk);
    drive(mode);
    #1;
    if (!rst) begin
      chk("rst_accept", cmd_in_accept, 0);
      chk("rst_cmd_vld", cmd_out_vld, 0);
      chk("rst_cmd_out", cmd_out, 0);
      chk("rst_pop", rsp_in_pop, 0);
      chk("rst_rsp_vld", rsp_out_vld, 0);
      chk("rst_rsp_out", rsp_out, 0);
      chk("rst_bad_cnt", bad_uid_cnt_r, 0);
      model_reset();
      return;
    end
    free = !m_vld || !cmd_out_full_r;
    found = 0; g = 0;
    for (int k = 0; k < N && !found; k++)
      if (cmd_in_vld[(m_rr + k) % N]) begin found = 1; g = (m_rr + k) % N; end
    stamp = g * (1 << LOW_W) + int'(cmd_in[g].uid) % (1 << LOW_W);
    bad = stamp == UID_ONES;
    exp_acc = (free && found) ? N'(1 << g) : '0;
    exp_dlv = m_busy ? m_owed & ~rsp_out_full_r : '0;
    chk("accept", cmd_in_accept, exp_acc);
    chk("cmd_vld", cmd_out_vld, m_vld);
    if (m_vld) chk("cmd_out", cmd_out, m_cmd);
    chk("pop", rsp_in_pop, !m_busy && rsp_in_vld);
    chk("rsp_vld", rsp_out_vld, exp_dlv);
    if (m_busy) chk("rsp_out", rsp_out, m_rsp);
    chk("bad_cnt", bad_uid_cnt_r, m_bc);
    chk("drop_cnt", drop_cnt_r, 0);
    if (free) begin
      m_vld = found && !bad;
      if (m_vld) begin m_cmd = cmd_in[g]; m_cmd.uid = UID_W'(stamp); end
    end
    if (free && found) begin
      m_rr = (g + 1) % N;
      if (bad && m_bc < 255) m_bc++;
    end
    if (m_busy) begin
      m_owed &= ~exp_dlv;
      if (m_owed == '0) m_busy = 0;
    end else if (rsp_in_vld) begin
      m_busy = 1;
      m_rsp = rsp_in;
      m_owed = int'(rsp_in.uid) == UID_ONES ? '1 : N'(1 << (int'(rsp_in.uid) >> LOW_W));
    end
  endtask

  initial begin
    cmd_in = '0; cmd_in_vld = '0; cmd_out_full_r = 0; rsp_in_vld = 0;
    rsp_in = '0; rsp_out_full_r = '0;
    model_reset();
    #1;
    chk("init_cmd_vld", cmd_out_vld, 0);
    chk("init_rsp_vld", rsp_out_vld, 0);
    chk("init_pop", rsp_in_pop, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 40; i++) step(3);
    for (int i = 0; i < 400; i++) step(0);
    for (int i = 0; i < 300; i++) step(1);
    chk("bad_cnt_sat", bad_uid_cnt_r, 255);
    for (int i = 0; i < 600; i++) step(2);
    for (int i = 0; i < 200; i++) step(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ob_port_arb.md
Name: ob_port_arb

Overview:
- N-port front-end arbiter for the order-book controller.
- Shares the single command ingress among N_PORTS clients with round-robin fairness.
- Stamps the source port into each command uid.
- Routes controller responses back: unicast by uid port field; trade messages (uid all-ones) are broadcast to every port.

Parameters:
N_PORTS, 4, number of client ports; power of 2, >= 2
PORT_W, $clog2(N_PORTS), width of port field stamped into uid MSBs
CNT_W, 8, width of saturating error counters

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
cmd_in_vld  input  N_PORTS  per-port command valid
cmd_in  input  N_PORTS x ob_pkg::cmd_t  per-port command
cmd_in_accept  output  N_PORTS  one-hot grant; command taken this cycle
cmd_out_full_r  input  1  downstream command queue full
cmd_out_vld  output  1  registered command valid
cmd_out  output  ob_pkg::cmd_t  registered stamped command
rsp_in_vld  input  1  controller response available
rsp_in  input  ob_pkg::rsp_t  controller response
rsp_in_pop  output  1  response taken this cycle
rsp_out_full_r  input  N_PORTS  per-port response sink full
rsp_out_vld  output  N_PORTS  per-port response strobe
rsp_out  output  ob_pkg::rsp_t  shared response bus (registered copy)
bad_uid_cnt_r  output  CNT_W  commands discarded for reserved uid
drop_cnt_r  output  CNT_W  reserved; always 0 (all PORT_W values map to a valid port)

Behaviour:
- Reset (rst=0, async):
  - cmd_out_vld=0, cmd_out=0, rsp_out_vld=0, rsp_out=0.
  - Response register empty, sent-mask=0, rr_ptr=0, both counters=0.
- Command stage:
  - Stage is free when ~cmd_out_vld, or when (cmd_out_vld & ~cmd_out_full_r), i.e. draining this cycle.
  - When free, grant the first requesting port scanning rr_ptr, rr_ptr+1 .. wrapping mod N_PORTS.
  - Assert cmd_in_accept[g] the same cycle. Next cycle rr_ptr = (g+1) mod N_PORTS; rr_ptr is unchanged with no grant.
  - The stamped uid replaces uid[UID_W-1 -: PORT_W] with g. Latency 1: the stamped command appears on cmd_out the next cycle.
  - If the stamped uid equals all-ones (reserved broadcast id): command is accepted but not loaded; bad_uid_cnt_r increments (saturating). The rr_ptr update still applies.
  - Stage holds cmd_out stable while cmd_out_full_r=1. No grants are made while the stage is not free.
  - Simultaneous drain and grant: the new command loads, giving back-to-back throughput of 1/cycle.
- Response path FSM:
  - States: R_IDLE, R_UNI, R_BCAST.
  - R_IDLE: if rsp_in_vld, assert rsp_in_pop and latch rsp_in into rsp_out. If uid == '1, go to R_BCAST with mask=0; else go to R_UNI with dst = uid MSBs.
  - R_UNI: when ~rsp_out_full_r[dst], pulse rsp_out_vld[dst] for 1 cycle and go to R_IDLE.
  - R_BCAST: each cycle, pulse rsp_out_vld[i] for every i with ~mask[i] & ~rsp_out_full_r[i], and set those mask bits. When the mask becomes all-ones, go to R_IDLE. Each port receives a broadcast exactly once.
  - rsp_out is held stable from latch until return to R_IDLE. The next pop occurs no earlier than the cycle after delivery completes, so minimum response spacing is 2 cycles.
- Command and response paths are independent; both may advance in the same cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-transfer discards the latched command/response without delivery. No accept or pop strobes are generated while rst=0.

Test Plan:
- All 4 ports request continuously, cmd_out_full_r=0 -> grants 0,1,2,3,0,...; port 2 uid 0x005 appears as uid with MSBs=2 one cycle later.
- Port 1 single command while cmd_out_full_r=1 for 3 cycles -> cmd_out held constant 3 cycles, no further accepts; on release, next grant is in the drain cycle.
- Response uid MSBs=3 with rsp_out_full_r[3]=1 for 2 cycles -> rsp_out_vld[3] pulses once in cycle 3; no other port strobes; rsp_in_pop once.
- Trade response uid '1 with rsp_out_full_r=4'b0101 then 0 -> ports 1,3 strobe in cycle 1, ports 0,2 in cycle 2; return to R_IDLE.
- Port 3 command with uid low bits all-ones -> accepted, not forwarded, bad_uid_cnt_r=1; 300 such commands -> counter stays at 255.
- rst pulled low during R_BCAST with mask=4'b0011 -> all outputs 0 immediately; after release, the next response is delivered normally, and the original broadcast is not replayed.
